// File: rtl/adler32_checker.sv
// adler32_checker
//   Link-sink Adler-32 checker. A frame is a byte count (size/size_valid), a
//   contiguous byte stream (data_start marks byte 0) and an expected checksum
//   word (exp_checksum/exp_valid) that may arrive any time from SIZED onward.
//   The result is reported with a one-cycle done pulse.
//
//   Ports
//     clk, reset            single clock, synchronous active-high reset
//     size, size_valid      byte count, captured in IDLE
//     data_start, data      first-byte marker (SIZED only) and stream byte
//     exp_checksum,
//     exp_valid             expected {B,A}; latched, last one wins
//     busy                  not IDLE
//     done                  one-cycle result pulse
//     match                 computed == expected, held until next done
//     checksum              running {B,A}, held until next frame start
//     proto_err             sticky strobe-in-wrong-state flag (reset clears)
//     timeout               with done: expected word never arrived
//
//   Optional feature: define ADLER_TIMEOUT_EN to bound the wait for the
//   expected word to TIMEOUT_CYC cycles; otherwise timeout is tied low.
module adler32_checker #(
  parameter int unsigned SIZE_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SIZE_W-1:0] size,
  input  logic              size_valid,
  input  logic              data_start,
  input  logic [7:0]        data,
  input  logic [31:0]       exp_checksum,
  input  logic              exp_valid,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [31:0]       checksum,
  output logic              proto_err,
  output logic              timeout
);

  localparam logic [16:0] MOD = 17'd65521;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIZED,
    S_DATA,
    S_WAIT_EXP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic [SIZE_W-1:0]  cnt_q, cnt_d;     // bytes still to come while in DATA
  logic [31:0]        exp_q, exp_d;
  logic               exp_seen_q, exp_seen_d;
  logic               done_q, done_d;
  logic               match_q, match_d;
  logic               proto_err_q, proto_err_d;
  logic               timeout_q, timeout_d;
  logic               consume;
  logic               last_byte;
  logic               tmo;

`ifdef ADLER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0]      tcnt_q, tcnt_d;
`endif

  // One Adler-32 byte step; both sums stay below 2*65521 so one conditional
  // subtract per sum is enough.
  function automatic logic [31:0] adler_step(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [7:0]  d);
    logic [16:0] a1;
    logic [16:0] b1;
    a1 = {1'b0, a} + {9'd0, d};
    if (a1 >= MOD) a1 = a1 - MOD;
    b1 = {1'b0, b} + a1;
    if (b1 >= MOD) b1 = b1 - MOD;
    return {b1[15:0], a1[15:0]};
  endfunction

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    exp_seen_d  = exp_seen_q;
    done_d      = 1'b0;
    match_d     = match_q;
    proto_err_d = proto_err_q;
    timeout_d   = 1'b0;
    consume     = 1'b0;
    last_byte   = 1'b0;
    tmo         = 1'b0;
`ifdef ADLER_TIMEOUT_EN
    tcnt_d      = '0;
`endif

    if (size_valid && state_q != S_IDLE) proto_err_d = 1'b1;
    if (data_start && state_q != S_SIZED) proto_err_d = 1'b1;
    if (exp_valid && state_q == S_IDLE) proto_err_d = 1'b1;

    if (exp_valid && (state_q == S_SIZED || state_q == S_DATA ||
                      state_q == S_WAIT_EXP)) begin
      exp_d      = exp_checksum;
      exp_seen_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (size_valid) begin
          size_d     = size;
          a_d        = 16'd1;
          b_d        = '0;
          exp_d      = '0;
          exp_seen_d = 1'b0;
          state_d    = S_SIZED;
        end
      end
      S_SIZED: begin
        if (data_start) begin
          if (size_q == '0) begin
            last_byte = 1'b1;
          end else begin
            consume = 1'b1;
            cnt_d   = size_q - SIZE_W'(1);
            if (size_q == SIZE_W'(1)) last_byte = 1'b1;
            else                      state_d   = S_DATA;
          end
        end
      end
      S_DATA: begin
        consume = 1'b1;
        cnt_d   = cnt_q - SIZE_W'(1);
        if (cnt_q == SIZE_W'(1)) last_byte = 1'b1;
      end
      S_WAIT_EXP: begin
        if (exp_seen_d) begin
          state_d = S_DONE;
        end else begin
`ifdef ADLER_TIMEOUT_EN
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
            tmo     = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (consume) {b_d, a_d} = adler_step(a_q, b_q, data);

    // The last byte (or size==0 start) goes straight to DONE when the
    // expected word is already known, including one arriving this cycle.
    if (last_byte) state_d = exp_seen_d ? S_DONE : S_WAIT_EXP;

    if (state_d == S_DONE) begin
      done_d    = 1'b1;
      match_d   = tmo ? 1'b0 : ({b_d, a_d} == exp_d);
      timeout_d = tmo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= 16'd1;
      b_q         <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      exp_seen_q  <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      proto_err_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef ADLER_TIMEOUT_EN
      tcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      exp_seen_q  <= exp_seen_d;
      done_q      <= done_d;
      match_q     <= match_d;
      proto_err_q <= proto_err_d;
      timeout_q   <= timeout_d;
`ifdef ADLER_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign match     = match_q;
  assign checksum  = {b_q, a_q};
  assign proto_err = proto_err_q;
`ifdef ADLER_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule
